// File: rtl/gsz_pkg.sv
// Shared types and constants for the 1-D curve-fitting predictor scheduler.
// History records carry the last three reconstructed values of one lane.
package gsz_pkg;
    localparam int DW        = 32;
    localparam int LANES_DEF = 4;
    localparam int LANE_W    = $clog2(LANES_DEF);
    localparam int HIST_MAX  = 3;

    typedef struct packed {
        logic [DW-1:0] h1;
        logic [DW-1:0] h2;
        logic [DW-1:0] h3;
        logic [1:0]    cnt;
        logic          busy;
    } hist_t;
endpackage

// File: rtl/fit_1d_sched_if.sv
// Sample-in / issue-out / feedback-in bundle of the 1-D fit scheduler.
// master drives samples and feedback; slave is the scheduler.
interface fit_1d_sched_if #(
    parameter int LANES = 4,
    parameter int DW    = 32
);
    localparam int LW = $clog2(LANES);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [LW-1:0] in_lane;
    logic          in_first;
    logic          pred_valid;
    logic [DW-1:0] pred_data;
    logic [DW-1:0] pred_p1;
    logic [DW-1:0] pred_p2;
    logic [DW-1:0] pred_p3;
    logic [1:0]    pred_hist_cnt;
    logic [LW-1:0] pred_lane;
    logic          fb_valid;
    logic [LW-1:0] fb_lane;
    logic [DW-1:0] fb_value;
    logic          idle;
    logic          err;

    modport master (
        output in_valid, in_data, in_lane, in_first, fb_valid, fb_lane, fb_value,
        input  in_ready, pred_valid, pred_data, pred_p1, pred_p2, pred_p3,
               pred_hist_cnt, pred_lane, idle, err
    );
    modport slave (
        input  in_valid, in_data, in_lane, in_first, fb_valid, fb_lane, fb_value,
        output in_ready, pred_valid, pred_data, pred_p1, pred_p2, pred_p3,
               pred_hist_cnt, pred_lane, idle, err
    );
endinterface

// File: rtl/fit_hist_bank.sv
// Per-lane reconstructed-value history and busy bits. Feedback shifts the
// history of a busy lane; an accepted in_first sample wipes it.
module fit_hist_bank
    import gsz_pkg::*;
#(
    parameter int LANES = 4,
    localparam int LW   = $clog2(LANES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          acc_i,
    input  logic [LW-1:0] acc_lane_i,
    input  logic          acc_first_i,
    input  logic          fb_valid_i,
    input  logic [LW-1:0] fb_lane_i,
    input  logic [DW-1:0] fb_value_i,
    input  logic [LW-1:0] rd_lane_i,
    output hist_t         rd_hist_o,
    output logic          fb_spur_o,
    output logic          idle_nxt_o
);
    hist_t hist_q [LANES];
    hist_t hist_d [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            hist_d[l] = hist_q[l];
            if (acc_i && acc_lane_i == LW'(l)) begin
                hist_d[l].busy = 1'b1;
                if (acc_first_i) begin
                    hist_d[l].h1  = '0;
                    hist_d[l].h2  = '0;
                    hist_d[l].h3  = '0;
                    hist_d[l].cnt = '0;
                end
            end else if (fb_valid_i && fb_lane_i == LW'(l) && hist_q[l].busy) begin
                hist_d[l].h3   = hist_q[l].h2;
                hist_d[l].h2   = hist_q[l].h1;
                hist_d[l].h1   = fb_value_i;
                hist_d[l].busy = 1'b0;
                if (hist_q[l].cnt != 2'(HIST_MAX))
                    hist_d[l].cnt = hist_q[l].cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) hist_q[l] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) hist_q[l] <= hist_d[l];
        end
    end

    assign rd_hist_o = hist_q[rd_lane_i];
    // Busy is judged before this cycle's accept, so no same-cycle bypass exists.
    assign fb_spur_o = fb_valid_i & ~hist_q[fb_lane_i].busy;

    always_comb begin
        idle_nxt_o = 1'b1;
        for (int l = 0; l < LANES; l++)
            if (hist_d[l].busy) idle_nxt_o = 1'b0;
    end
endmodule

// File: rtl/fit_1d_sched.sv
// Issue scheduler for the 1-D fit predictor: one sample per cycle across lanes,
// each lane held off until its reconstructed value has come back.
module fit_1d_sched
    import gsz_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = gsz_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    fit_1d_sched_if.slave bus
);
    localparam int LW = $clog2(LANES);

    hist_t         rd_hist;
    logic          accept, spur, idle_nxt;
    logic          pvld_q, pvld_d;
    logic [DW-1:0] pdata_q, pdata_d;
    logic [DW-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [1:0]    pcnt_q, pcnt_d;
    logic [LW-1:0] plane_q, plane_d;
    logic          err_q, err_d;
    logic          idle_q, idle_d;

    assign bus.in_ready = ~rd_hist.busy;
    assign accept       = bus.in_valid & bus.in_ready;

    fit_hist_bank #(.LANES(LANES)) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_i       (accept),
        .acc_lane_i  (bus.in_lane),
        .acc_first_i (bus.in_first),
        .fb_valid_i  (bus.fb_valid),
        .fb_lane_i   (bus.fb_lane),
        .fb_value_i  (bus.fb_value),
        .rd_lane_i   (bus.in_lane),
        .rd_hist_o   (rd_hist),
        .fb_spur_o   (spur),
        .idle_nxt_o  (idle_nxt)
    );

    always_comb begin
        pvld_d  = accept;
        pdata_d = pdata_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        pcnt_d  = pcnt_q;
        plane_d = plane_q;
        err_d   = err_q | spur;
        idle_d  = idle_nxt & ~accept;
        if (accept) begin
            pdata_d = bus.in_data;
            plane_d = bus.in_lane;
            if (bus.in_first) begin
                p1_d   = '0;
                p2_d   = '0;
                p3_d   = '0;
                pcnt_d = '0;
            end else begin
                p1_d   = rd_hist.h1;
                p2_d   = rd_hist.h2;
                p3_d   = rd_hist.h3;
                pcnt_d = rd_hist.cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pvld_q  <= 1'b0;
            pdata_q <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            pcnt_q  <= '0;
            plane_q <= '0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            pvld_q  <= pvld_d;
            pdata_q <= pdata_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            pcnt_q  <= pcnt_d;
            plane_q <= plane_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.pred_valid    = pvld_q;
    assign bus.pred_data     = pdata_q;
    assign bus.pred_p1       = p1_q;
    assign bus.pred_p2       = p2_q;
    assign bus.pred_p3       = p3_q;
    assign bus.pred_hist_cnt = pcnt_q;
    assign bus.pred_lane     = plane_q;
    assign bus.err           = err_q;
    assign bus.idle          = idle_q;
endmodule

// File: tb/tb_fit_1d_sched.sv
// Scoreboard bench for fit_1d_sched: a lane model predicts each issue,
// the monitor pops and compares on every pred_valid strobe.
module tb_fit_1d_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fit_1d_sched_if #(.LANES(4), .DW(32)) bus ();
    fit_1d_sched #(.LANES(4), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0] d, p1, p2, p3;
        logic [1:0]  c;
        logic [1:0]  ln;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mh1[4], mh2[4], mh3[4];
    int          mcnt[4];
    bit          mbusy[4];
    bit          merr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            mh1[l] = '0; mh2[l] = '0; mh3[l] = '0; mcnt[l] = 0; mbusy[l] = 0;
        end
        merr = 0;
        q.delete();
    endtask

    // One cycle: optionally offer a sample and/or return feedback. Entered and
    // left 1 time unit after a rising edge.
    task automatic cyc(input bit di, input int ln, input bit fi, input logic [31:0] d,
                       input bit df, input int fl, input logic [31:0] fv);
        exp_t e;
        bit   acc;
        bus.in_valid = di;  bus.in_lane = 2'(ln); bus.in_first = fi; bus.in_data = d;
        bus.fb_valid = df;  bus.fb_lane = 2'(fl); bus.fb_value = fv;
        #1;
        acc = di && !mbusy[ln];
        if (di) chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !mbusy[ln]});
        if (df) begin
            if (mbusy[fl]) begin
                mh3[fl] = mh2[fl]; mh2[fl] = mh1[fl]; mh1[fl] = fv;
                if (mcnt[fl] < 3) mcnt[fl]++;
                mbusy[fl] = 0;
            end else merr = 1;
        end
        if (acc) begin
            e.d = d; e.ln = 2'(ln);
            if (fi) begin
                e.p1 = '0; e.p2 = '0; e.p3 = '0; e.c = 2'd0;
                mh1[ln] = '0; mh2[ln] = '0; mh3[ln] = '0; mcnt[ln] = 0;
            end else begin
                e.p1 = mh1[ln]; e.p2 = mh2[ln]; e.p3 = mh3[ln]; e.c = 2'(mcnt[ln]);
            end
            q.push_back(e);
            mbusy[ln] = 1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.fb_valid = 1'b0;
    endtask

    task automatic send(input int ln, input bit fi, input logic [31:0] d);
        cyc(1, ln, fi, d, 0, 0, 32'h0);
    endtask

    task automatic fb(input int ln, input logic [31:0] v);
        cyc(0, 0, 0, 32'h0, 1, ln, v);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.pred_valid) begin
            if (q.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("pred_data", {32'd0, bus.pred_data}, {32'd0, e.d});
                chk("pred_lane", {62'd0, bus.pred_lane}, {62'd0, e.ln});
                chk("pred_p1", {32'd0, bus.pred_p1}, {32'd0, e.p1});
                chk("pred_p2", {32'd0, bus.pred_p2}, {32'd0, e.p2});
                chk("pred_p3", {32'd0, bus.pred_p3}, {32'd0, e.p3});
                chk("pred_cnt", {62'd0, bus.pred_hist_cnt}, {62'd0, e.c});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        bus.in_valid = 0; bus.in_lane = 0; bus.in_first = 0; bus.in_data = 0;
        bus.fb_valid = 0; bus.fb_lane = 0; bus.fb_value = 0;

        // reset held with noise on every input
        repeat (4) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom); bus.in_lane = 2'($urandom); bus.in_first = 1'($urandom);
            bus.in_data = $urandom; bus.fb_valid = 1'($urandom); bus.fb_lane = 2'($urandom);
            bus.fb_value = $urandom;
            @(negedge clk);
            chk("rst_pred_valid", {63'd0, bus.pred_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
            chk("rst_idle", {63'd0, bus.idle}, 64'd1);
            chk("rst_err", {63'd0, bus.err}, 64'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 0; bus.fb_valid = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // first sample, then lane 0 stays blocked until feedback
        send(0, 1, 32'h3fa66666);
        chk("idle_busy", {63'd0, bus.idle}, 64'd0);
        send(0, 0, 32'h11111111);
        cyc(1, 0, 0, 32'h22222222, 1, 0, 32'h3fcccccd);
        send(0, 0, 32'h3fa66666);
        fb(0, 32'h3fe66666);
        send(0, 0, 32'h3fa66666);
        fb(0, 32'h3fdae148);
        send(0, 0, 32'h3fa66666);
        fb(0, 32'h3f800000);
        send(0, 0, 32'h40000000);
        fb(0, 32'h40400000);

        // interleave across all lanes
        send(0, 0, 32'h50000000);
        send(1, 0, 32'h50000001);
        send(2, 0, 32'h50000002);
        send(3, 0, 32'h50000003);
        send(0, 0, 32'h50000010);
        cyc(1, 0, 0, 32'h50000010, 1, 0, 32'h41000000);
        send(0, 0, 32'h50000010);
        fb(2, 32'h41100000);
        cyc(1, 2, 0, 32'h50000012, 1, 1, 32'h41200000);
        send(1, 0, 32'h50000011);

        // spurious feedback on an idle lane
        fb(2, 32'h41300000);
        chk("err_before", {63'd0, bus.err}, {63'd0, merr});
        fb(2, 32'h3e6ee632);
        chk("err_set", {63'd0, bus.err}, 64'd1);
        send(2, 0, 32'h50000022);
        chk("err_sticky", {63'd0, bus.err}, 64'd1);

        // warm lane 1 to saturation, then restart its block
        fb(1, 32'h41400000);
        send(1, 0, 32'h50000021);
        fb(1, 32'h41500000);
        send(1, 0, 32'h50000031);
        fb(1, 32'h41600000);
        send(1, 1, 32'h3e702c81);
        fb(1, 32'h41700000);
        fb(0, 32'h41800000);
        fb(2, 32'h41900000);
        fb(3, 32'h41a00000);
        chk("idle_drained", {63'd0, bus.idle}, 64'd1);
        chk("err_held", {63'd0, bus.err}, {63'd0, merr});

        // reset in the middle of traffic with three lanes busy
        send(0, 0, 32'h60000000);
        send(1, 0, 32'h60000001);
        send(3, 0, 32'h60000003);
        chk("idle_traffic", {63'd0, bus.idle}, 64'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", {63'd0, bus.pred_valid}, 64'd0);
        chk("mid_rst_err", {63'd0, bus.err}, 64'd0);
        chk("mid_rst_idle", {63'd0, bus.idle}, 64'd1);
        for (int l = 0; l < 4; l++) begin
            bus.in_lane = 2'(l);
            #1;
            chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {63'd0, bus.idle}, 64'd1);
        @(posedge clk); #1;
        send(0, 0, 32'h70000000);
        fb(0, 32'h42000000);
        @(negedge clk);
        chk("sb_empty", 64'(q.size()), 64'd0);
        chk("final_idle", {63'd0, bus.idle}, 64'd1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/fit_1d_sched.md
Name: fit_1d_sched

Overview:
- Issue scheduler for the 1-D curve-fitting predictor stage of the compressor.
- Interleaves up to LANES independent 1-D data streams so that each lane's reconstructed-value feedback loop is closed before its next sample issues.
- Holds per-lane history of the last three reconstructed values and presents them with each new sample.
- Sits between the input sample stream and the predictor (proceed1/2/3 inputs); the quantizer's reconstructed value returns on the feedback port.

Parameters:
- LANES, 4, number of interleaved streams; power of two, at least 2.
- DW, 32, sample width (IEEE-754 single bit pattern, treated as opaque bits).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_data  in  DW  sample value.
- in_lane  in  clog2(LANES)  stream id of sample.
- in_first  in  1  sample starts a new block on its lane; clears that lane's history.
- pred_valid  out  1  one-cycle strobe: issue to predictor.
- pred_data  out  DW  issued sample.
- pred_p1, pred_p2, pred_p3  out  DW each  most recent, second and third most recent reconstructed values of the lane.
- pred_hist_cnt  out  2  number of valid history entries, 0..3.
- pred_lane  out  clog2(LANES)  lane of issued sample.
- fb_valid  in  1  reconstructed value returning.
- fb_lane  in  clog2(LANES)  lane of returning value.
- fb_value  in  DW  reconstructed value.
- idle  out  1  no lane busy and pred_valid low.
- err  out  1  sticky: feedback received for a non-busy lane.

Behaviour:
- Per-lane state: h1, h2, h3 (DW each), cnt (0..3), busy.
- Reset (async assert, sync release):
  - All per-lane state cleared to 0.
  - pred_* = 0, pred_valid = 0, err = 0, idle = 1.
- in_ready: combinational, equals ~busy[in_lane]. It does not depend on fb_valid in the same cycle; there is no bypass.
- On accept of sample S for lane L (registered; outputs valid the next cycle, 1-cycle latency):
  - pred_valid = 1, pred_data = S, pred_lane = L.
  - If in_first = 1: pred_p1..p3 = 0, pred_hist_cnt = 0, and cnt[L] is cleared.
  - Otherwise: pred_p1..p3 = h1..h3 of L, pred_hist_cnt = cnt[L].
  - busy[L] is set.
- Without an accept, pred_valid = 0 and the other pred_* outputs hold their last values.
- On fb_valid with busy[fb_lane] = 1:
  - h3 <= h2, h2 <= h1, h1 <= fb_value.
  - cnt saturates at 3.
  - busy cleared. The lane is ready the cycle after feedback.
- On fb_valid with busy[fb_lane] = 0: err set, sticky until reset; lane state unchanged.
- Simultaneous accept on lane A and feedback on lane B (A != B): both take effect in the same cycle.
- Accept and feedback on the same lane in the same cycle cannot occur, because in_ready is low while the lane is busy.
- An in_first sample on a busy lane waits like any other sample. It never discards an outstanding feedback.
- No downstream backpressure: the predictor is a fixed-latency pipeline.
- Throughput: one issue per cycle when successive samples target non-busy lanes.
- Per-lane issue rate is bounded by the loop latency plus 1 cycle.
- idle is registered: high when all busy bits are 0 and pred_valid = 0.

Decomposition:
- Shared package gsz_pkg holds:
  - DW default.
  - LANE_W = clog2(LANES).
  - A history record type {h1, h2, h3, cnt, busy}.
  - Constant HIST_MAX = 3.
- One sub-module, fit_hist_bank, holds the per-lane history registers, the shift-on-feedback logic, the clear-on-first logic, and the busy bits. It provides a read port for the issue path.
- fit_1d_sched keeps the issue register, in_ready, err and idle.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → pred_valid = 0, in_ready = 1, idle = 1, err = 0. Assert rst_n mid-stream with 3 lanes busy → all state cleared immediately, idle = 1 after release.
- First sample: lane 0, in_first = 1, in_data = 32'h3fa66666 → next cycle pred_valid = 1, pred_data = 32'h3fa66666, p1..p3 = 0, pred_hist_cnt = 0; in_ready low for lane 0 until feedback.
- History build: lane 0 feedbacks 32'h3fcccccd, 32'h3fe66666, 32'h3fdae148 (each after an issue), then issue 32'h3fa66666 → p1 = 32'h3fdae148, p2 = 32'h3fe66666, p3 = 32'h3fcccccd, pred_hist_cnt = 3. A fourth feedback shifts these values and cnt stays 3.
- Interleave: back-to-back samples on lanes 0, 1, 2, 3 → four consecutive pred_valid cycles with pred_lane 0, 1, 2, 3. A fifth sample on lane 0 sees in_ready = 0 until the cycle after fb_lane = 0. A lane 1 feedback in the same cycle as a lane 2 accept → both take effect.
- Spurious feedback: fb_valid on idle lane 2, fb_value = 32'h3e6ee632 → err = 1 and stays 1; lane 2 history unchanged (next issue shows the prior p1..p3).
- in_first on a warmed lane: lane 1 with cnt = 3, then in_first sample 32'h3e702c81 → p1..p3 = 0, pred_hist_cnt = 0.
